gate_path_arbiter: RTL and testbench

//  Round-robin arbiter that time-shares one selectable buffer/inverter gate path among NUM_REQ requesters.

---
 rtl/gate_pkg.sv | 13 +
 rtl/gate_path.sv | 21 ++
 rtl/gate_path_arbiter.sv | 156 +++++++++++++++
 tb/tb_gate_path_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate-path arbiter: FSM encoding and path modes.
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic MODE_BUF = 1'b0;
  localparam logic MODE_INV = 1'b1;

endpackage : gate_pkg

// File: rtl/gate_path.sv
// Selectable buffer/inverter path built from inverter stages.
// The buffer leg is two inverters in series; the invert leg taps after the first.
module gate_path
  import gate_pkg::*;
(
  input  logic in,
  input  logic invert,
  output logic out
);

  logic stage1;
  logic stage2;

  // Two inverter stages; the mux picks which tap drives the output.
  always_comb begin
    stage1 = ~in;
    stage2 = ~stage1;
    out    = (invert == MODE_INV) ? stage1 : stage2;
  end

endmodule : gate_path

// File: rtl/gate_path_arbiter.sv
// Round-robin arbiter that time-shares one gate_path among NUM_REQ requesters.
// A winner's din/mode are latched, held on the path for SETTLE_CYCLES clocks,
// then the path output is sampled and returned with a one-cycle ack pulse.
module gate_path_arbiter
  import gate_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  input  logic [NUM_REQ-1:0] mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] ack,
  output logic               dout,
  output logic [ID_W-1:0]    dout_id,
  output logic               dout_valid,
  output logic               busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  // First asserted request at or after ptr, wrapping NUM_REQ-1 -> 0.
  // The doubled vector shifted right by ptr puts ptr's bit at position 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0]    ptr);
    logic [2*NUM_REQ-1:0] dbl;
    int                   k;
    dbl = {r, r} >> ptr;
    k   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (dbl[i]) k = i;
    end
    return ID_W'((int'(ptr) + k) % NUM_REQ);
  endfunction

  state_t               state_q, state_nxt;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_nxt;
  logic [ID_W-1:0]      id_q, id_nxt;
  logic                 din_q, din_nxt;
  logic                 mode_q, mode_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [NUM_REQ-1:0]   gnt_q, gnt_nxt;
  logic [NUM_REQ-1:0]   ack_q, ack_nxt;
  logic                 dout_q, dout_nxt;
  logic [ID_W-1:0]      dout_id_q, dout_id_nxt;
  logic                 valid_q, valid_nxt;
  logic                 busy_q, busy_nxt;
  logic [ID_W-1:0]      pick;
  logic                 path_out;

  // Shared path is driven only from the latched operands, so requester
  // changes after the grant never disturb a settling transaction.
  gate_path u_path (
    .in     (din_q),
    .invert (mode_q),
    .out    (path_out)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Datapath and registered outputs; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      id_q      <= '0;
      din_q     <= 1'b0;
      mode_q    <= MODE_BUF;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      dout_q    <= 1'b0;
      dout_id_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_nxt;
      id_q      <= id_nxt;
      din_q     <= din_nxt;
      mode_q    <= mode_nxt;
      cnt_q     <= cnt_nxt;
      gnt_q     <= gnt_nxt;
      ack_q     <= ack_nxt;
      dout_q    <= dout_nxt;
      dout_id_q <= dout_id_nxt;
      valid_q   <= valid_nxt;
      busy_q    <= busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every target gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_nxt   = state_q;
    rr_ptr_nxt  = rr_ptr_q;
    id_nxt      = id_q;
    din_nxt     = din_q;
    mode_nxt    = mode_q;
    cnt_nxt     = cnt_q;
    gnt_nxt     = gnt_q;
    ack_nxt     = '0;
    dout_nxt    = dout_q;
    dout_id_nxt = dout_id_q;
    valid_nxt   = 1'b0;
    busy_nxt    = busy_q;
    pick        = rr_pick(req, rr_ptr_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          id_nxt    = pick;
          din_nxt   = din[pick];
          mode_nxt  = mode[pick];
          gnt_nxt   = NUM_REQ'(1) << pick;
          busy_nxt  = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_nxt = DONE;
        else             cnt_nxt   = cnt_q - 1'b1;
      end
      DONE: begin
        ack_nxt     = gnt_q;
        valid_nxt   = 1'b1;
        dout_nxt    = path_out;
        dout_id_nxt = id_q;
        rr_ptr_nxt  = ID_W'((int'(id_q) + 1) % NUM_REQ);
        gnt_nxt     = '0;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt        = gnt_q;
  assign ack        = ack_q;
  assign dout       = dout_q;
  assign dout_id    = dout_id_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;

endmodule : gate_path_arbiter

// File: tb/tb_gate_path_arbiter.sv
// Directed bench for gate_path_arbiter (NUM_REQ=4, SETTLE_CYCLES=2).
module tb_gate_path_arbiter;

  localparam int N      = 4;
  localparam int SETTLE = 2;
  localparam int ID_W   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, din, mode;
  logic [N-1:0]  gnt, ack;
  logic          dout, dout_valid, busy;
  logic [ID_W-1:0] dout_id;

  int n_checks = 0;
  int n_pass   = 0;

  gate_path_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din        (din),
    .mode       (mode),
    .gnt        (gnt),
    .ack        (ack),
    .dout       (dout),
    .dout_id    (dout_id),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until dout_valid is seen, bounded; returns the ticks taken.
  task automatic wait_ack(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dout_valid && n < 20);
    check({tag, "_valid_seen"}, 32'(dout_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  // Single transaction: req dropped right after grant.
  task automatic do_one(input string tag, input logic [N-1:0] r, input logic [N-1:0] d,
                        input logic [N-1:0] m, input int exp_id, input logic exp_dout);
    int n;
    req = r; din = d; mode = m;
    tick();
    check({tag, "_gnt"},  32'(gnt),  32'(1) << exp_id);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_ack_idle"}, 32'(ack), 32'd0);
    req = '0;
    wait_ack(tag, n);
    check({tag, "_latency"}, 32'(n), 32'(SETTLE + 1));
    check({tag, "_ack"},     32'(ack), 32'(1) << exp_id);
    check({tag, "_dout"},    32'(dout), 32'(exp_dout));
    check({tag, "_dout_id"}, 32'(dout_id), 32'(exp_id));
    check({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    int n;
    logic [N-1:0] pat;
    rst_n = 1'b0; req = '0; din = '0; mode = '0;
    #12;
    // Reset state
    check("rst_gnt",   32'(gnt), 32'd0);
    check("rst_ack",   32'(ack), 32'd0);
    check("rst_dout",  32'(dout), 32'd0);
    check("rst_id",    32'(dout_id), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: buffer of 1 on requester 0
    do_one("t1", 4'b0001, 4'b0001, 4'b0000, 0, 1'b1);
    tick();
    check("t1_ack_pulse", 32'(ack), 32'd0);
    check("t1_valid_pulse", 32'(dout_valid), 32'd0);

    // 2: invert on requester 2, both data values
    do_one("t2a", 4'b0100, 4'b0100, 4'b0100, 2, 1'b0);
    do_one("t2b", 4'b0100, 4'b0000, 4'b0100, 2, 1'b1);

    // 3: all requesting, round-robin from pointer 0
    do_reset();
    pat = 4'b1010;
    req = 4'b1111; din = pat; mode = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      wait_ack("t3", n);
      check("t3_spacing", 32'(n), 32'(SETTLE + 2));
      check("t3_id",   32'(dout_id), 32'(i % N));
      check("t3_dout", 32'(dout), 32'(pat[i % N]));
    end
    req = '0;
    tick();

    // 4: reset mid-SETTLE of id 1 (pointer is 1 here)
    req = 4'b0010; din = 4'b0010;
    tick();
    check("t4_gnt", 32'(gnt), 32'b0010);
    req = '0;
    tick();
    rst_n = 1'b0;
    #2;
    check("t4_gnt_async", 32'(gnt), 32'd0);
    check("t4_busy_async", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_no_ack", 32'({ack, dout_valid}), 32'd0);
    end
    do_one("t4b", 4'b1111, 4'b0001, 4'b0000, 0, 1'b1);

    // 5: req[3] dropped and din[3] toggled mid-transaction
    req = 4'b1000; din = 4'b1000; mode = 4'b0000;
    tick();
    check("t5_gnt", 32'(gnt), 32'b1000);
    tick();
    req = '0; din = 4'b0000;
    wait_ack("t5", n);
    check("t5_ack",  32'(ack), 32'b1000);
    check("t5_dout", 32'(dout), 32'd1);
    check("t5_id",   32'(dout_id), 32'd3);

    // 6: after id 3, req=1001 wraps to 0 then 3 then 0
    req = 4'b1001; din = 4'b0000; mode = 4'b1000;
    wait_ack("t6a", n);
    check("t6a_id", 32'(dout_id), 32'd0);
    check("t6a_dout", 32'(dout), 32'd0);
    wait_ack("t6b", n);
    check("t6b_id", 32'(dout_id), 32'd3);
    check("t6b_dout", 32'(dout), 32'd1);
    check("t6b_ack", 32'(ack), 32'b1000);
    wait_ack("t6c", n);
    check("t6c_id", 32'(dout_id), 32'd0);
    req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_gate_path_arbiter
